// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC/fetch controller
package pc_fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_EXEC = 2'b11
    } state_e;

    // PC_Sel encodings; 2'b11 falls through to sequential
    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // JALR clears bit 0 of the computed target
    localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/pc_fetch_ctrl_pc_inc.sv
// rtl/pc_fetch_ctrl_pc_inc.sv - PC_Inc adder block: PC+4 and PC+Imm
//
// Ports:
//   pc_i      current PC
//   imm_i     immediate operand
//   pc_4_o    pc_i + 4 (mod 2^32)
//   pc_imm_o  pc_i + imm_i (mod 2^32)
module pc_fetch_ctrl_pc_inc (
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    output logic [31:0] pc_4_o,
    output logic [31:0] pc_imm_o
);

    assign pc_4_o   = pc_i + 32'd4;
    assign pc_imm_o = pc_i + imm_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - architectural PC register and instruction fetch sequencer
//
// Ports:
//   CLK, RSTN            clock, synchronous active-low reset
//   Imm_Out, RS1_Data    next-PC operands (immediate, JALR base)
//   PC_Sel, Br_Taken     next-PC selection, evaluated only at retire
//   Stall, Instr_Done    retirement control (Stall wins)
//   Imem_Req/Gnt/Addr    request handshake to instruction memory
//   Imem_Rvalid/Rdata    fetched word return
//   Instr, Instr_Valid   held instruction to decode/execute
//   PC, PC_4             current PC and PC+4
//   Misalign_Trap        one-cycle pulse after a misaligned retire target
//   Fetch_Timeout        sticky flag, set when memory never returns data
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] Imm_Out,
    input  logic [31:0] RS1_Data,
    input  logic [1:0]  PC_Sel,
    input  logic        Br_Taken,
    input  logic        Stall,
    input  logic        Instr_Done,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic [31:0] PC_4,
    output logic        Misalign_Trap,
    output logic        Fetch_Timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_4;
    logic [31:0] pc_imm;
    logic [31:0] jalr_sum;
    logic [31:0] target;

    pc_fetch_ctrl_pc_inc u_pc_inc (
        .pc_i     (pc_q),
        .imm_i    (Imm_Out),
        .pc_4_o   (pc_4),
        .pc_imm_o (pc_imm)
    );

    assign jalr_sum = RS1_Data + Imm_Out;

    // Candidate next PC; only committed on the retire cycle
    always_comb begin
        target = pc_4;
        case (PC_Sel)
            PCSEL_SEQ:  target = pc_4;
            PCSEL_BR:   target = Br_Taken ? pc_imm : pc_4;
            PCSEL_JALR: target = jalr_sum & JALR_MASK;
            default:    target = pc_4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (Imem_Gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                // Data arriving on the last allowed cycle still counts
                if (Imem_Rvalid) begin
                    instr_d = Imem_Rdata;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    pc_d      = TRAP_VEC;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (Instr_Done && !Stall) begin
                    state_d = S_REQ;
                    if (target[1:0] != 2'b00) begin
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VEC;
            instr_q    <= NOP_INSTR;
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    assign Imem_Req      = (state_q == S_REQ);
    assign Imem_Addr     = pc_q;
    assign Instr         = instr_q;
    assign Instr_Valid   = (state_q == S_EXEC);
    assign PC            = pc_q;
    assign PC_4          = pc_4;
    assign Misalign_Trap = misalign_q;
    assign Fetch_Timeout = timeout_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [31:0] Imm_Out;
    logic [31:0] RS1_Data;
    logic [1:0]  PC_Sel;
    logic        Br_Taken;
    logic        Stall;
    logic        Instr_Done;
    logic        Imem_Gnt;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic        Misalign_Trap;
    logic        Fetch_Timeout;

    int tests  = 0;
    int failed = 0;

    pc_fetch_ctrl dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .Imm_Out       (Imm_Out),
        .RS1_Data      (RS1_Data),
        .PC_Sel        (PC_Sel),
        .Br_Taken      (Br_Taken),
        .Stall         (Stall),
        .Instr_Done    (Instr_Done),
        .Imem_Gnt      (Imem_Gnt),
        .Imem_Rvalid   (Imem_Rvalid),
        .Imem_Rdata    (Imem_Rdata),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Instr         (Instr),
        .Instr_Valid   (Instr_Valid),
        .PC            (PC),
        .PC_4          (PC_4),
        .Misalign_Trap (Misalign_Trap),
        .Fetch_Timeout (Fetch_Timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one fetch: Gnt on the first Req cycle, Rvalid the next cycle
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        int n = 0;
        while (Imem_Req !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_req"}, {31'd0, Imem_Req}, 32'd1);
        chk({tag, "_addr"}, Imem_Addr, exp_addr);
        Imem_Gnt = 1'b1;
        @(negedge CLK);
        Imem_Gnt    = 1'b0;
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = data;
        @(negedge CLK);
        Imem_Rvalid = 1'b0;
        chk({tag, "_valid"}, {31'd0, Instr_Valid}, 32'd1);
        chk({tag, "_instr"}, Instr, data);
    endtask

    // Retire the held instruction and check the committed PC
    task automatic retire(input string tag, input logic [1:0] sel, input logic taken,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic [31:0] exp_pc, input logic exp_trap);
        PC_Sel     = sel;
        Br_Taken   = taken;
        Imm_Out    = imm;
        RS1_Data   = rs1;
        Instr_Done = 1'b1;
        @(negedge CLK);
        Instr_Done = 1'b0;
        chk({tag, "_pc"}, PC, exp_pc);
        chk({tag, "_valid"}, {31'd0, Instr_Valid}, 32'd0);
        chk({tag, "_trap"}, {31'd0, Misalign_Trap}, {31'd0, exp_trap});
    endtask

    initial begin
        RSTN        = 1'b0;
        Imm_Out     = '0;
        RS1_Data    = '0;
        PC_Sel      = 2'b00;
        Br_Taken    = 1'b0;
        Stall       = 1'b0;
        Instr_Done  = 1'b0;
        Imem_Gnt    = 1'b0;
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = '0;

        repeat (2) @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_req", {31'd0, Imem_Req}, 32'd0);
        chk("rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("rst_trap", {31'd0, Misalign_Trap}, 32'd0);
        chk("rst_tmo", {31'd0, Fetch_Timeout}, 32'd0);
        chk("rst_pc4", PC_4, 32'h4);
        RSTN = 1'b1;

        // First fetch: REQ, WAIT, EXEC -> valid on cycle 3
        fetch("f0", 32'h0, 32'h0000_0093);
        chk("f0_pc4", PC_4, 32'h4);
        retire("seq0", 2'b00, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);

        fetch("f4", 32'h4, 32'h1111_1111);
        retire("br_to40", 2'b01, 1'b1, 32'h0000_003C, 32'h0, 32'h40, 1'b0);

        fetch("f40a", 32'h40, 32'h2222_2222);
        retire("br_neg", 2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h30, 1'b0);

        fetch("f30", 32'h30, 32'h3333_3333);
        retire("br_back", 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'h40, 1'b0);

        fetch("f40b", 32'h40, 32'h4444_4444);
        retire("br_nt", 2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h44, 1'b0);

        fetch("f44", 32'h44, 32'h5555_5555);
        retire("sel11", 2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'h48, 1'b0);

        // JALR to 0x1002: bit 1 set -> trap vector and one-cycle pulse
        fetch("f48", 32'h48, 32'h6666_6666);
        retire("jalr_mis", 2'b10, 1'b0, 32'h0000_0002, 32'h0000_1001, 32'h100, 1'b1);
        @(negedge CLK);
        chk("mis_pulse_end", {31'd0, Misalign_Trap}, 32'd0);
        chk("mis_req_held", {31'd0, Imem_Req}, 32'd1);
        chk("mis_addr", Imem_Addr, 32'h100);

        // JALR to 0xFFFF_FFFC, then sequential wraps to 0
        fetch("f100a", 32'h100, 32'h7777_7777);
        retire("jalr_top", 2'b10, 1'b0, 32'h0000_0004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0);
        chk("pc4_wrap", PC_4, 32'h0);
        fetch("ftop", 32'hFFFF_FFFC, 32'h8888_8888);
        retire("seq_wrap", 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // JALR with odd sum: bit 0 cleared, no trap
        fetch("f0b", 32'h0, 32'h9999_9999);
        retire("jalr_mask", 2'b10, 1'b0, 32'h0000_0005, 32'h0000_2000, 32'h2004, 1'b0);

        // Stall holds retirement while Instr_Done is high
        fetch("f2004", 32'h2004, 32'hAAAA_AAAA);
        PC_Sel     = 2'b00;
        Stall      = 1'b1;
        Instr_Done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_pc", PC, 32'h2004);
            chk("stall_instr", Instr, 32'hAAAA_AAAA);
            chk("stall_valid", {31'd0, Instr_Valid}, 32'd1);
        end
        Stall = 1'b0;
        @(negedge CLK);
        Instr_Done = 1'b0;
        chk("unstall_pc", PC, 32'h2008);
        chk("unstall_valid", {31'd0, Instr_Valid}, 32'd0);

        // Rvalid on the 16th WAIT cycle beats the timeout
        chk("late_addr", Imem_Addr, 32'h2008);
        Imem_Gnt = 1'b1;
        @(negedge CLK);
        Imem_Gnt = 1'b0;
        repeat (15) @(negedge CLK);
        chk("late_wait", {31'd0, Instr_Valid}, 32'd0);
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = 32'hBBBB_BBBB;
        @(negedge CLK);
        Imem_Rvalid = 1'b0;
        chk("late_valid", {31'd0, Instr_Valid}, 32'd1);
        chk("late_instr", Instr, 32'hBBBB_BBBB);
        chk("late_tmo", {31'd0, Fetch_Timeout}, 32'd0);
        retire("late_seq", 2'b00, 1'b0, 32'h0, 32'h0, 32'h200C, 1'b0);

        // Rvalid never arrives: timeout after 16 WAIT cycles
        chk("tmo_addr", Imem_Addr, 32'h200C);
        Imem_Gnt = 1'b1;
        @(negedge CLK);
        Imem_Gnt = 1'b0;
        repeat (15) @(negedge CLK);
        chk("tmo_not_yet", {31'd0, Fetch_Timeout}, 32'd0);
        chk("tmo_wait_noreq", {31'd0, Imem_Req}, 32'd0);
        @(negedge CLK);
        chk("tmo_flag", {31'd0, Fetch_Timeout}, 32'd1);
        chk("tmo_pc", PC, 32'h100);
        chk("tmo_req", {31'd0, Imem_Req}, 32'd1);
        chk("tmo_req_addr", Imem_Addr, 32'h100);
        @(negedge CLK);
        chk("tmo_sticky", {31'd0, Fetch_Timeout}, 32'd1);

        // Reset in WAIT, then a stray Rvalid is ignored
        Imem_Gnt = 1'b1;
        @(negedge CLK);
        Imem_Gnt = 1'b0;
        RSTN     = 1'b0;
        @(negedge CLK);
        RSTN        = 1'b1;
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("rw_pc", PC, 32'h0);
        chk("rw_instr", Instr, 32'h0000_0013);
        chk("rw_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("rw_tmo", {31'd0, Fetch_Timeout}, 32'd0);
        chk("rw_req", {31'd0, Imem_Req}, 32'd1);
        Imem_Rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
